uba_intr_ctrl: RTL
==================

# uba_intr_ctrl

Bus-side interrupt responder for the Unibus adapter. Collects level-sensitive interrupt requests from up to NDEV Unibus devices (DZ11, LP20, RH11, ...) and picks one winner. Runs the acknowledge/vector handshake that device-side interrupt blocks expect, then hands the captured 16-bit vector to the CPU-side interrupt logic. Sits between the device interrupt outputs and the UBA CPU interface.

## Interface
- NDEV, 4 — number of device request slots (2..8).
- VECT_CYCLES, 2 — cycles `dev_vect` is held high (≥1); vector sampled on the last one.
- HOLD_CYCLES, 3 — post-transaction holdoff cycles before re-arbitration (≥2).

- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- dev_irq  input  NDEV  level interrupt request per device.
- dev_ack  output  NDEV  one-hot acknowledge to the granted device.
- dev_vect  output  NDEV  one-hot vector-cycle strobe to the granted device.
- dev_vdata  input  16  vector driven by the granted device during its vector cycle.
- cpu_irq  output  1  interrupt request to the CPU.
- cpu_iack  input  1  CPU vector request (single-cycle pulse).
- cpu_vect  output  16  vector delivered to the CPU.
- cpu_vect_vld  output  1  one-cycle strobe; `cpu_vect` is valid.
- cpu_passive  output  1  with `cpu_vect_vld`: passive release, `cpu_vect` = 0.

## Operation
- Reset values: all outputs 0; state IDLE; winner index 0; round-robin pointer 0.
- States: IDLE, REQ, ACK, VECT, DONE, HOLD.
- IDLE: if any `dev_irq` bit is set, latch the winner index and go to REQ.
- REQ: `cpu_irq`=1.
  - If `dev_irq[win]` drops before `cpu_iack`: cancel, clear `cpu_irq`, return to IDLE. No ack is issued.
  - On `cpu_iack`: go to ACK.
  - `cpu_iack` outside REQ is ignored.
- ACK, one cycle: `dev_ack[win]`=1, `cpu_irq`=0.
  - If `dev_irq[win]` is already 0, set the passive flag.
  - Go to VECT.
- VECT, VECT_CYCLES cycles: `dev_vect[win]`=1.
  - On the last cycle, register `dev_vdata`, or 0 if the passive flag is set.
  - Go to DONE.
- DONE, one cycle:
  - `dev_vect`=0.
  - `cpu_vect_vld`=1; `cpu_vect` holds the registered value until the next DONE.
  - `cpu_passive` reflects the passive flag.
  - Go to HOLD.
- HOLD, HOLD_CYCLES cycles: no arbitration. This lets the device drop its request, which takes 2 cycles after `dev_vect` falls. Then go to IDLE.
- Arbitration is combinational over `dev_irq`, registered on the IDLE→REQ edge only. The winner cannot change mid-transaction; new or higher-priority requests wait.
- Simultaneous requests are resolved by the priority rule (see Configuration).
- Reset mid-transaction: all strobes drop immediately (asynchronously). No vector is delivered.
- Only one bit of `dev_ack` or `dev_vect` is ever high, and never both in the same cycle.

## Timing
- Request to `cpu_irq`: 1 cycle (IDLE sees `dev_irq`, then REQ).
- `cpu_iack` to `dev_ack`: 1 cycle.
- `dev_ack` to `dev_vect` rising: 1 cycle.
- `cpu_iack` to `cpu_vect_vld`: 2 + VECT_CYCLES cycles (4 at default).
- Back-to-back service: the next `cpu_irq` comes no earlier than HOLD_CYCLES+1 cycles after `cpu_vect_vld`.
- All outputs are registered.

## Configuration
- UBA_INTR_RR_EN defined: rotating priority.
  - The search starts at the pointer index and wraps modulo NDEV.
  - After each non-cancelled grant, the pointer becomes (win+1) mod NDEV.
  - Passive grants advance the pointer too; cancels do not.
- UBA_INTR_RR_EN undefined: fixed priority, lowest index wins. The pointer logic is absent.

## Test plan
- Single request, slot 2, `dev_vdata`=0o300:
  - `cpu_irq` 1 cycle later.
  - `cpu_iack` → `dev_ack`=0b0100 for 1 cycle, then `dev_vect`=0b0100 for 2 cycles.
  - `cpu_vect_vld` with `cpu_vect`=0o300, `cpu_passive`=0.
- Requests on slots 1 and 3 together, fixed priority:
  - Slot 1 served first.
  - Slot 3 served after its holdoff.
  - With UBA_INTR_RR_EN and three rounds of constant requests, the grant order is 1,3,1.
- Cancel: slot 0 raises, then drops before `cpu_iack` → `cpu_irq` falls next cycle, no `dev_ack`, state IDLE.
- Passive release: slot 0 drops `dev_irq` in the same cycle as `cpu_iack` → `dev_ack` still pulses, then `cpu_vect`=0 with `cpu_passive`=1.
- Reset (`rst`=0) asserted while `dev_vect`=0b0001 → all outputs 0 immediately. After release, a pending request restarts from IDLE with `cpu_irq` 1 cycle later.

Source files
------------

// File: rtl/uba_intr_ctrl.sv
// Unibus adapter interrupt responder: arbitrates device requests, runs the ack/vector handshake, hands the vector to the CPU.
// Optional rotating priority is enabled by defining UBA_INTR_RR_EN; the default build uses fixed lowest-index priority.
module uba_intr_ctrl #(
  parameter int NDEV        = 4,
  parameter int VECT_CYCLES = 2,
  parameter int HOLD_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NDEV-1:0] dev_irq,
  output logic [NDEV-1:0] dev_ack,
  output logic [NDEV-1:0] dev_vect,
  input  logic [15:0]     dev_vdata,
  output logic            cpu_irq,
  input  logic            cpu_iack,
  output logic [15:0]     cpu_vect,
  output logic            cpu_vect_vld,
  output logic            cpu_passive,
  output logic [2:0]      dbg_state
);

  localparam int IW   = $clog2(NDEV);
  localparam int CMAX = (VECT_CYCLES > HOLD_CYCLES) ? VECT_CYCLES : HOLD_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_ACK  = 3'd2,
    S_VECT = 3'd3,
    S_DONE = 3'd4,
    S_HOLD = 3'd5
  } state_t;

  // Handshake: cpu_irq stays high in REQ until a cpu_iack pulse is seen; the
  // device sees dev_ack for one cycle, then dev_vect for VECT_CYCLES cycles and
  // must drive dev_vdata by the last of them; cpu_vect_vld pulses once per grant.

  state_t          state_q, state_d;
  logic [IW-1:0]   win_q, win_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            passive_q, passive_d;
  logic [NDEV-1:0] dev_ack_q, dev_ack_d;
  logic [NDEV-1:0] dev_vect_q, dev_vect_d;
  logic            cpu_irq_q, cpu_irq_d;
  logic [15:0]     cpu_vect_q, cpu_vect_d;
  logic            cpu_vect_vld_q, cpu_vect_vld_d;
  logic            cpu_passive_q, cpu_passive_d;
  logic [IW-1:0]   arb_win;
  logic            vect_last;
  logic            hold_last;
  logic [NDEV-1:0] win_oh;
`ifdef UBA_INTR_RR_EN
  logic [IW-1:0]   ptr_q, ptr_d;
`endif

  // First set bit of req found when scanning upward from start, wrapping.
  function automatic logic [IW-1:0] pick(input logic [NDEV-1:0] req, input logic [IW-1:0] start);
    logic [IW-1:0] r;
    logic          found;
    int            j;
    r     = '0;
    found = 1'b0;
    for (int k = 0; k < NDEV; k++) begin
      j = (int'(start) + k) % NDEV;
      if (!found && req[j]) begin
        r     = IW'(j);
        found = 1'b1;
      end
    end
    return r;
  endfunction

`ifdef UBA_INTR_RR_EN
  assign arb_win = pick(dev_irq, ptr_q);
`else
  assign arb_win = pick(dev_irq, {IW{1'b0}});
`endif

  assign vect_last = (cnt_q == CW'(VECT_CYCLES - 1));
  assign hold_last = (cnt_q == CW'(HOLD_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      win_q          <= '0;
      cnt_q          <= '0;
      passive_q      <= 1'b0;
      dev_ack_q      <= '0;
      dev_vect_q     <= '0;
      cpu_irq_q      <= 1'b0;
      cpu_vect_q     <= '0;
      cpu_vect_vld_q <= 1'b0;
      cpu_passive_q  <= 1'b0;
`ifdef UBA_INTR_RR_EN
      ptr_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      win_q          <= win_d;
      cnt_q          <= cnt_d;
      passive_q      <= passive_d;
      dev_ack_q      <= dev_ack_d;
      dev_vect_q     <= dev_vect_d;
      cpu_irq_q      <= cpu_irq_d;
      cpu_vect_q     <= cpu_vect_d;
      cpu_vect_vld_q <= cpu_vect_vld_d;
      cpu_passive_q  <= cpu_passive_d;
`ifdef UBA_INTR_RR_EN
      ptr_q          <= ptr_d;
`endif
    end
  end

  // The winner is latched only when leaving IDLE, so it is stable for the whole transaction.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    passive_d = passive_q;
`ifdef UBA_INTR_RR_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|dev_irq) begin
          state_d   = S_REQ;
          win_d     = arb_win;
          passive_d = 1'b0;
        end
      end
      S_REQ: begin
        if (cpu_iack) begin
          state_d = S_ACK;
        end else if (!dev_irq[win_q]) begin
          state_d = S_IDLE;
        end
      end
      S_ACK: begin
        passive_d = ~dev_irq[win_q];
        cnt_d     = '0;
        state_d   = S_VECT;
`ifdef UBA_INTR_RR_EN
        ptr_d     = (win_q == IW'(NDEV - 1)) ? '0 : win_q + 1'b1;
`endif
      end
      S_VECT: begin
        if (vect_last) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (hold_last) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode the next state so every strobe comes straight from a flop.
  always_comb begin
    win_oh         = NDEV'(1) << win_d;
    dev_ack_d      = (state_d == S_ACK)  ? win_oh : '0;
    dev_vect_d     = (state_d == S_VECT) ? win_oh : '0;
    cpu_irq_d      = (state_d == S_REQ);
    cpu_vect_vld_d = (state_d == S_DONE);
    cpu_passive_d  = (state_d == S_DONE) && passive_q;
    cpu_vect_d     = cpu_vect_q;
    if (state_q == S_VECT && vect_last) begin
      cpu_vect_d = passive_q ? 16'h0000 : dev_vdata;
    end
  end

  assign dev_ack      = dev_ack_q;
  assign dev_vect     = dev_vect_q;
  assign cpu_irq      = cpu_irq_q;
  assign cpu_vect     = cpu_vect_q;
  assign cpu_vect_vld = cpu_vect_vld_q;
  assign cpu_passive  = cpu_passive_q;
  assign dbg_state    = state_q;

endmodule
